// File: rtl/umi_stream_s2mm_writer_pkg.sv
// Shared UMI message constants, command bit positions and writer FSM encoding
// for the stream-to-memory writer.
package umi_stream_s2mm_writer_pkg;

   localparam logic [4:0] REQ_WRITE  = 5'h03;
   localparam logic [4:0] REQ_POSTED = 5'h05;
   localparam logic [4:0] RESP_WRITE = 5'h04;

   localparam int CMD_OPCODE_LSB = 0;
   localparam int CMD_SIZE_LSB   = 5;
   localparam int CMD_LEN_LSB    = 8;
   localparam int CMD_EOM_BIT    = 22;
   localparam int CMD_EOF_BIT    = 23;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Single-beat write command: len=0, eom=1, eof marks the frame's final beat.
   function automatic logic [31:0] write_cmd(input logic       posted,
                                             input logic [2:0] size,
                                             input logic       eof);
      logic [31:0] c;
      c = '0;
      c[CMD_OPCODE_LSB +: 5] = posted ? REQ_POSTED : REQ_WRITE;
      c[CMD_SIZE_LSB +: 3]   = size;
      c[CMD_LEN_LSB +: 8]    = 8'h00;
      c[CMD_EOM_BIT]         = 1'b1;
      c[CMD_EOF_BIT]         = eof;
      return c;
   endfunction

endpackage

// File: rtl/umi_stream_s2mm_writer_addrgen.sv
// Byte offset into the circular buffer window: steps one beat per accepted
// beat, wraps modulo WINDOW and restarts at 0 after a frame's last beat.
module umi_stream_s2mm_writer_addrgen #(
   parameter int DW     = 256,
   parameter int WINDOW = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      advance,
   input  logic                      last,
   output logic [$clog2(WINDOW)-1:0] offset
);

   localparam int OW = $clog2(WINDOW);
   localparam logic [OW-1:0] STEP = OW'(DW / 8);

   // WINDOW is a power of two, so dropping the carry is the modulo.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         offset <= '0;
      end else if (advance) begin
         offset <= last ? '0 : offset + STEP;
      end
   end

endmodule

// File: rtl/umi_stream_s2mm_writer.sv
// Turns each USI beat from the s2mm FIFO into a single-beat UMI write into a
// circular memory window, with optional ack tracking and an outstanding limit.
module umi_stream_s2mm_writer
   import umi_stream_s2mm_writer_pkg::*;
#(
   parameter int AW     = 64,
   parameter int CW     = 32,
   parameter int DW     = 256,
   parameter int WINDOW = 4096,
   parameter int MAXOUT = 8
) (
   input  logic          umi_clk,
   input  logic          umi_reset,
   input  logic          enable,
   input  logic          posted,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] src_addr,
   input  logic          usi_in_valid,
   input  logic          usi_in_last,
   input  logic [DW-1:0] usi_in_data,
   output logic          usi_in_ready,
   output logic          umi_out_valid,
   output logic [CW-1:0] umi_out_cmd,
   output logic [AW-1:0] umi_out_dstaddr,
   output logic [AW-1:0] umi_out_srcaddr,
   output logic [DW-1:0] umi_out_data,
   input  logic          umi_out_ready,
   input  logic          umi_in_valid,
   input  logic [CW-1:0] umi_in_cmd,
   output logic          umi_in_ready,
   output logic          busy,
   output logic          frame_done,
   output logic          err,
   output state_t        dbg_state
);

   localparam int OW = $clog2(WINDOW);
   localparam logic [2:0] SIZE = 3'($clog2(DW / 8));

   // Handshakes: a transfer happens on a cycle where valid & ready are both
   // high at the rising clock edge; valid never waits on ready, and the
   // request fields hold stable while umi_out_valid & ~umi_out_ready.

   state_t          state;
   logic            posted_q;
   logic [AW-1:0]   base_q;
   logic [7:0]      outstanding;
   logic [OW-1:0]   offset;
   logic            stall;
   logic            accept;
   logic            issue_acked;
   logic            resp_ok;
   logic            resp_bad;
   logic            unused_cmd_bits;

   assign stall = ~posted_q &
                  ((9'(outstanding) + 9'(umi_out_valid)) >= 9'(MAXOUT));
   assign usi_in_ready = (state == ST_RUN) & (~umi_out_valid | umi_out_ready) & ~stall;
   assign accept       = usi_in_valid & usi_in_ready;

   // The opcode travels with the request, so a posted frame starting while an
   // acked request is still queued is counted correctly.
   assign issue_acked = umi_out_valid & umi_out_ready &
                        (umi_out_cmd[CMD_OPCODE_LSB +: 5] == REQ_WRITE);
   assign resp_ok  = umi_in_valid & (umi_in_cmd[CMD_OPCODE_LSB +: 5] == RESP_WRITE) &
                     (outstanding != 8'd0);
   assign resp_bad = umi_in_valid & ~resp_ok;

   assign umi_in_ready    = 1'b1;
   assign busy            = (state != ST_IDLE) | (outstanding != 8'd0);
   assign dbg_state       = state;
   assign unused_cmd_bits = ^umi_in_cmd[CW-1:5];

   umi_stream_s2mm_writer_addrgen #(
      .DW     (DW),
      .WINDOW (WINDOW)
   ) u_addrgen (
      .clk     (umi_clk),
      .rst     (umi_reset),
      .advance (accept),
      .last    (usi_in_last),
      .offset  (offset)
   );

   always_ff @(posedge umi_clk or posedge umi_reset) begin
      if (umi_reset) begin
         state      <= ST_IDLE;
         posted_q   <= 1'b0;
         base_q     <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state    <= ST_RUN;
                  posted_q <= posted;
                  base_q   <= base_addr;
               end
            end
            ST_RUN: begin
               if (accept && usi_in_last) begin
                  if (posted_q) begin
                     state      <= ST_IDLE;
                     frame_done <= 1'b1;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (outstanding == 8'd0 && !umi_out_valid) begin
                  state      <= ST_IDLE;
                  frame_done <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge umi_clk or posedge umi_reset) begin
      if (umi_reset) begin
         umi_out_valid   <= 1'b0;
         umi_out_cmd     <= '0;
         umi_out_dstaddr <= '0;
         umi_out_srcaddr <= '0;
         umi_out_data    <= '0;
      end else if (accept) begin
         umi_out_valid   <= 1'b1;
         umi_out_cmd     <= CW'(write_cmd(posted_q, SIZE, usi_in_last));
         umi_out_dstaddr <= base_q + AW'(offset);
         umi_out_srcaddr <= src_addr;
         umi_out_data    <= usi_in_data;
      end else if (umi_out_ready) begin
         umi_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge umi_clk or posedge umi_reset) begin
      if (umi_reset) begin
         outstanding <= 8'd0;
         err         <= 1'b0;
      end else begin
         case ({issue_acked, resp_ok})
            2'b10:   outstanding <= outstanding + 8'd1;
            2'b01:   outstanding <= outstanding - 8'd1;
            default: outstanding <= outstanding;
         endcase
         if (resp_bad) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_umi_stream_s2mm_writer.sv
// Self-checking bench for umi_stream_s2mm_writer: random beats, a model of the
// expected request stream, and directed ack/backpressure/error/reset scenarios.
module tb_umi_stream_s2mm_writer;
   import umi_stream_s2mm_writer_pkg::*;

   localparam int AW = 64, CW = 32, DW = 256, WINDOW = 128, MAXOUT = 2, STEP = DW / 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic          enable = 0, posted = 0;
   logic [AW-1:0] base_addr = '0, src_addr = '0;
   logic          usi_in_valid = 0, usi_in_last = 0, usi_in_ready;
   logic [DW-1:0] usi_in_data = '0;
   logic          umi_out_valid, umi_out_ready = 1;
   logic [CW-1:0] umi_out_cmd;
   logic [AW-1:0] umi_out_dstaddr, umi_out_srcaddr;
   logic [DW-1:0] umi_out_data;
   logic          umi_in_valid = 0, umi_in_ready;
   logic [CW-1:0] umi_in_cmd = '0;
   logic          busy, frame_done, err;
   state_t        dbg_state;

   umi_stream_s2mm_writer #(.AW(AW), .CW(CW), .DW(DW), .WINDOW(WINDOW), .MAXOUT(MAXOUT)) dut (
      .umi_clk(clk), .umi_reset(rst), .enable(enable), .posted(posted),
      .base_addr(base_addr), .src_addr(src_addr),
      .usi_in_valid(usi_in_valid), .usi_in_last(usi_in_last), .usi_in_data(usi_in_data),
      .usi_in_ready(usi_in_ready),
      .umi_out_valid(umi_out_valid), .umi_out_cmd(umi_out_cmd), .umi_out_dstaddr(umi_out_dstaddr),
      .umi_out_srcaddr(umi_out_srcaddr), .umi_out_data(umi_out_data), .umi_out_ready(umi_out_ready),
      .umi_in_valid(umi_in_valid), .umi_in_cmd(umi_in_cmd), .umi_in_ready(umi_in_ready),
      .busy(busy), .frame_done(frame_done), .err(err), .dbg_state(dbg_state)
   );

   int n_tests = 0, n_fail = 0, fd_count = 0;

   // ---------------- reference model / scoreboard ----------------
   logic          m_posted = 1'b1;
   logic [AW-1:0] m_base = '0;
   int            m_off = 0;
   logic [AW-1:0] exp_dst_q[$], obs_dst_q[$], obs_src_q[$];
   logic [CW-1:0] exp_cmd_q[$], obs_cmd_q[$];
   logic [DW-1:0] exp_data_q[$], obs_data_q[$];

   function automatic logic [CW-1:0] model_cmd(input logic p, input logic l);
      logic [CW-1:0] c;
      c = '0;
      c[4:0]  = p ? 5'h05 : 5'h03;
      c[7:5]  = 3'($clog2(DW / 8));
      c[22]   = 1'b1;
      c[23]   = l;
      return c;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         m_off = 0;
      end else begin
         if (usi_in_valid && usi_in_ready) begin
            exp_dst_q.push_back(m_base + AW'(m_off));
            exp_cmd_q.push_back(model_cmd(m_posted, usi_in_last));
            exp_data_q.push_back(usi_in_data);
            m_off = usi_in_last ? 0 : (m_off + STEP) % WINDOW;
         end
         if (umi_out_valid && umi_out_ready) begin
            obs_dst_q.push_back(umi_out_dstaddr);
            obs_src_q.push_back(umi_out_srcaddr);
            obs_cmd_q.push_back(umi_out_cmd);
            obs_data_q.push_back(umi_out_data);
         end
         if (frame_done) fd_count++;
      end
   end

   task automatic clear_q();
      exp_dst_q.delete(); exp_cmd_q.delete(); exp_data_q.delete();
      obs_dst_q.delete(); obs_src_q.delete(); obs_cmd_q.delete(); obs_data_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_beat(input logic [DW-1:0] d, input logic l, input int budget);
      int n = 0;
      usi_in_valid = 1'b1; usi_in_data = d; usi_in_last = l;
      forever begin
         @(negedge clk);
         if (usi_in_ready) break;
         n++;
         if (n > budget) begin
            n_tests++; n_fail++;
            $display("FAIL beat_accept_timeout: no usi_in_ready within %0d cycles", budget);
            break;
         end
      end
      @(posedge clk); #1;
      usi_in_valid = 1'b0; usi_in_last = 1'b0;
   endtask

   task automatic send_resp(input logic [4:0] op);
      umi_in_valid = 1'b1; umi_in_cmd = CW'(op);
      @(posedge clk); #1;
      umi_in_valid = 1'b0; umi_in_cmd = '0;
   endtask

   task automatic start_frame(input logic p, input logic [AW-1:0] b);
      posted = p; base_addr = b; m_posted = p; m_base = b;
      src_addr = {$urandom, $urandom};
      enable = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [63:0] got[9], want[9];
      string nm[9];
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      nm = '{"rst_out_valid", "rst_in_ready_usi", "rst_umi_in_ready", "rst_busy", "rst_err",
             "rst_frame_done", "rst_cmd", "rst_dstaddr", "rst_state"};
      got  = '{64'(umi_out_valid), 64'(usi_in_ready), 64'(umi_in_ready), 64'(busy), 64'(err),
               64'(frame_done), 64'(umi_out_cmd), umi_out_dstaddr, 64'(dbg_state)};
      want = '{64'd0, 64'd0, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'(ST_IDLE)};
      for (int i = 0; i < 9; i++) begin
         n_tests++;
         if (got[i] !== want[i]) begin
            n_fail++; $display("FAIL %s: got %0h want %0h", nm[i], got[i], want[i]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_posted_frame();
      int fd0 = fd_count;
      clear_q();
      start_frame(1'b1, 64'h1000);
      for (int i = 0; i < 3; i++) send_beat(rand_data(), i == 2, 50);
      enable = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++;
      if (obs_dst_q.size() != 3) begin n_fail++; $display("FAIL posted_count: got %0d want 3", obs_dst_q.size()); end
      for (int i = 0; i < exp_dst_q.size(); i++) begin
         n_tests++;
         if (i >= obs_dst_q.size()) begin n_fail++; $display("FAIL posted_req %0d: missing", i); end
         else if (obs_dst_q[i] !== 64'h1000 + 64'(i * 32) || obs_dst_q[i] !== exp_dst_q[i] ||
                  obs_cmd_q[i] !== exp_cmd_q[i] || obs_data_q[i] !== exp_data_q[i] || obs_src_q[i] !== src_addr) begin
            n_fail++;
            $display("FAIL posted_req %0d: dst %0h cmd %0h want dst %0h cmd %0h", i, obs_dst_q[i], obs_cmd_q[i],
                     exp_dst_q[i], exp_cmd_q[i]);
         end
      end
      n_tests++;
      if (fd_count - fd0 != 1) begin n_fail++; $display("FAIL posted_frame_done: got %0d pulses want 1", fd_count - fd0); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL posted_busy_after: got %b want 0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      int offs[8] = '{0, 32, 64, 96, 0, 32, 0, 32};
      int fd0 = fd_count;
      clear_q();
      start_frame(1'b1, 64'h1000);
      for (int i = 0; i < 6; i++) send_beat(rand_data(), i == 5, 50);
      for (int i = 0; i < 2; i++) send_beat(rand_data(), i == 1, 50);
      enable = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++;
      if (obs_dst_q.size() != 8) begin n_fail++; $display("FAIL wrap_count: got %0d want 8", obs_dst_q.size()); end
      for (int i = 0; i < exp_dst_q.size(); i++) begin
         n_tests++;
         if (i >= obs_dst_q.size()) begin n_fail++; $display("FAIL wrap_req %0d: missing", i); end
         else if (obs_dst_q[i] !== 64'h1000 + 64'(offs[i]) || obs_dst_q[i] !== exp_dst_q[i] ||
                  obs_cmd_q[i] !== exp_cmd_q[i] || obs_data_q[i] !== exp_data_q[i]) begin
            n_fail++;
            $display("FAIL wrap_req %0d: dst %0h cmd %0h want dst %0h cmd %0h", i, obs_dst_q[i], obs_cmd_q[i],
                     exp_dst_q[i], exp_cmd_q[i]);
         end
      end
      n_tests++;
      if (fd_count - fd0 != 2) begin n_fail++; $display("FAIL wrap_frame_done: got %0d pulses want 2", fd_count - fd0); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int fd0 = fd_count;
      int n = 0;
      logic drv_done = 1'b0;
      logic [CW-1:0] h_cmd; logic [AW-1:0] h_dst; logic [DW-1:0] h_data;
      clear_q();
      umi_out_ready = 1'b1;
      start_frame(1'b1, 64'h4000);
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               if (i >= 3) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               send_beat(rand_data(), i == 9, 100);
            end
            enable = 1'b0;
            drv_done = 1'b1;
         end
         begin
            repeat (3) @(posedge clk);
            #1 umi_out_ready = 1'b0;
            @(negedge clk);
            h_cmd = umi_out_cmd; h_dst = umi_out_dstaddr; h_data = umi_out_data;
            n_tests++;
            if (umi_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", umi_out_valid); end
            for (int c = 0; c < 4; c++) begin
               @(negedge clk);
               n_tests++;
               if (umi_out_valid !== 1'b1 || umi_out_cmd !== h_cmd || umi_out_dstaddr !== h_dst || umi_out_data !== h_data) begin
                  n_fail++;
                  $display("FAIL bp_stable cycle %0d: valid %b dst %0h cmd %0h want valid 1 dst %0h cmd %0h",
                           c, umi_out_valid, umi_out_dstaddr, umi_out_cmd, h_dst, h_cmd);
               end
            end
            while (!drv_done && n < 1000) begin
               @(posedge clk); #1 umi_out_ready = 1'($urandom_range(0, 1));
               n++;
            end
            umi_out_ready = 1'b1;
         end
      join
      repeat (4) @(negedge clk);
      n_tests++;
      if (obs_dst_q.size() != 10) begin n_fail++; $display("FAIL bp_count: got %0d want 10", obs_dst_q.size()); end
      for (int i = 0; i < exp_dst_q.size(); i++) begin
         n_tests++;
         if (i >= obs_dst_q.size()) begin n_fail++; $display("FAIL bp_req %0d: missing", i); end
         else if (obs_dst_q[i] !== exp_dst_q[i] || obs_cmd_q[i] !== exp_cmd_q[i] || obs_data_q[i] !== exp_data_q[i]) begin
            n_fail++;
            $display("FAIL bp_req %0d: dst %0h cmd %0h want dst %0h cmd %0h", i, obs_dst_q[i], obs_cmd_q[i],
                     exp_dst_q[i], exp_cmd_q[i]);
         end
      end
      n_tests++;
      if (fd_count - fd0 != 1) begin n_fail++; $display("FAIL bp_frame_done: got %0d pulses want 1", fd_count - fd0); end
      @(posedge clk); #1;
   endtask

   task automatic test_acked_limit();
      int fd0 = fd_count;
      int n = 0;
      logic drv_done = 1'b0;
      clear_q();
      umi_out_ready = 1'b1;
      start_frame(1'b0, 64'h2000);
      fork
         begin
            for (int i = 0; i < 4; i++) send_beat(rand_data(), i == 3, 300);
            enable = 1'b0;
            drv_done = 1'b1;
         end
         begin
            repeat (10) @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (obs_dst_q.size() != 2 || usi_in_ready !== 1'b0 || busy !== 1'b1) begin
               n_fail++; $display("FAIL acked_limit_2: issued %0d ready %b busy %b want 2 0 1", obs_dst_q.size(), usi_in_ready, busy);
            end
            @(posedge clk); #1;
            send_resp(RESP_WRITE);
            repeat (6) @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (obs_dst_q.size() != 3 || usi_in_ready !== 1'b0) begin
               n_fail++; $display("FAIL acked_limit_3: issued %0d ready %b want 3 0", obs_dst_q.size(), usi_in_ready);
            end
            @(posedge clk); #1;
            send_resp(RESP_WRITE);
            repeat (6) @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (obs_dst_q.size() != 4 || busy !== 1'b1 || dbg_state !== ST_DRAIN || fd_count != fd0) begin
               n_fail++;
               $display("FAIL acked_drain: issued %0d busy %b state %0d done %0d want 4 1 %0d 0",
                        obs_dst_q.size(), busy, dbg_state, fd_count - fd0, ST_DRAIN);
            end
            @(posedge clk); #1;
            send_resp(RESP_WRITE);
            send_resp(RESP_WRITE);
            while (!drv_done && n < 500) begin @(posedge clk); n++; end
            repeat (4) @(negedge clk);
            n_tests++;
            if (busy !== 1'b0 || err !== 1'b0 || fd_count - fd0 != 1 || !drv_done) begin
               n_fail++;
               $display("FAIL acked_complete: busy %b err %b done %0d drv %b want 0 0 1 1", busy, err, fd_count - fd0, drv_done);
            end
         end
      join
      for (int i = 0; i < exp_dst_q.size(); i++) begin
         n_tests++;
         if (i >= obs_dst_q.size()) begin n_fail++; $display("FAIL acked_req %0d: missing", i); end
         else if (obs_dst_q[i] !== 64'h2000 + 64'(i * 32) || obs_cmd_q[i] !== exp_cmd_q[i] ||
                  obs_data_q[i] !== exp_data_q[i] || obs_src_q[i] !== src_addr) begin
            n_fail++;
            $display("FAIL acked_req %0d: dst %0h cmd %0h want dst %0h cmd %0h", i, obs_dst_q[i], obs_cmd_q[i],
                     64'h2000 + 64'(i * 32), exp_cmd_q[i]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_err();
      @(negedge clk);
      n_tests++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL err_initial: got %b want 0", err); end
      @(posedge clk); #1;
      send_resp(5'h02);
      repeat (2) @(negedge clk);
      n_tests++;
      if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL err_bad_opcode: err %b busy %b want 1 0", err, busy); end
      @(posedge clk); #1;
      send_resp(RESP_WRITE);
      repeat (5) @(negedge clk);
      n_tests++;
      if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL err_unexpected_ack: err %b busy %b want 1 0", err, busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midframe();
      int fd0;
      clear_q();
      umi_out_ready = 1'b1;
      start_frame(1'b1, 64'h3000);
      send_beat(rand_data(), 1'b0, 50);
      send_beat(rand_data(), 1'b0, 50);
      umi_out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (umi_out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || umi_out_dstaddr !== '0) begin
         n_fail++;
         $display("FAIL midreset_clear: valid %b busy %b err %b dst %0h want 0 0 0 0", umi_out_valid, busy, err, umi_out_dstaddr);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      umi_out_ready = 1'b1;
      clear_q();
      fd0 = fd_count;
      for (int i = 0; i < 2; i++) send_beat(rand_data(), i == 1, 50);
      enable = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++;
      if (obs_dst_q.size() != 2) begin n_fail++; $display("FAIL midreset_count: got %0d want 2", obs_dst_q.size()); end
      for (int i = 0; i < exp_dst_q.size(); i++) begin
         n_tests++;
         if (i >= obs_dst_q.size()) begin n_fail++; $display("FAIL midreset_req %0d: missing", i); end
         else if (obs_dst_q[i] !== 64'h3000 + 64'(i * 32) || obs_cmd_q[i] !== exp_cmd_q[i] || obs_data_q[i] !== exp_data_q[i]) begin
            n_fail++;
            $display("FAIL midreset_req %0d: dst %0h cmd %0h want dst %0h cmd %0h", i, obs_dst_q[i], obs_cmd_q[i],
                     64'h3000 + 64'(i * 32), exp_cmd_q[i]);
         end
      end
      n_tests++;
      if (fd_count - fd0 != 1) begin n_fail++; $display("FAIL midreset_frame_done: got %0d want 1", fd_count - fd0); end
      @(posedge clk); #1;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_posted_frame();
      test_wrap();
      test_backpressure();
      test_acked_limit();
      test_err();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
